vga_write_arbiter: RTL and testbench
====================================

VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 Parameter X_W, default 10, SHALL set the pixel X coordinate width.
REQ-002 Parameter Y_W, default 9, SHALL set the pixel Y coordinate width.
REQ-003 Parameter TIMEOUT, default 131072, SHALL set the maximum cycles one grant may be held.
REQ-004 clk  in  1  SHALL be the system clock; every register SHALL update on its rising edge.
REQ-005 resetn  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 req  in  4  SHALL carry one render-job request per port; the requester holds it high for the whole job. Port 0 is the urgent port (blackscreen); ports 1-3 are normal.
REQ-007 pix_valid  in  4  SHALL flag, per port, that the port presents a pixel this cycle.
REQ-008 x_in  in  4*X_W  SHALL carry per-port X, packed with port p at bits [p*X_W +: X_W].
REQ-009 y_in  in  4*Y_W  SHALL carry per-port Y, packed the same way.
REQ-010 col_in  in  12  SHALL carry per-port 3-bit colour, packed the same way.
REQ-011 gnt  out  4  SHALL be the one-hot or zero registered grant.
REQ-012 oX, oY, oColour  out  X_W, Y_W, 3  SHALL be the registered VGA pixel coordinates and colour.
REQ-013 oPlot  out  1  SHALL be the registered pixel write enable.
REQ-014 busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-015 oTimeout  out  1  SHALL be a one-cycle pulse when a grant is revoked by timeout.

Function
REQ-016 The arbiter SHALL implement a three-state machine: IDLE, GRANT, GAP.
REQ-017 In IDLE with req != 0, the winner SHALL be port 0 if req[0]=1; otherwise the first requesting port in round-robin order starting at last+1 (mod 4, skipping 0).
  - On the next edge: state=GRANT, gnt=onehot(winner), last=winner, hold counter=0.
REQ-018 In IDLE with req == 0, gnt SHALL stay 0 and state SHALL stay IDLE.
REQ-019 Grant latency SHALL be exactly one cycle from req sampled high in IDLE to gnt high.
REQ-020 In GRANT, each edge SHALL register the winner's pixel.
  - oPlot = pix_valid[g].
  - oX/oY/oColour = x_in/y_in/col_in of port g when pix_valid[g]=1; otherwise they hold their previous value.
  - Pixel-to-output latency is one cycle.
REQ-021 Pixels on non-granted ports SHALL be ignored; oPlot SHALL be 0 in every cycle after a cycle in which the state is not GRANT.
REQ-022 GRANT SHALL exit to GAP, with gnt cleared at that edge, on the first of these (priority in this order):
  - (a) req[g]=0 (normal release);
  - (b) req[0]=1 while g != 0 (preemption);
  - (c) hold counter = TIMEOUT-1 (oTimeout pulses in the GAP cycle).
REQ-023 On the exit cycle, a pixel with pix_valid[g]=1 SHALL still be written.
REQ-024 The hold counter SHALL increment once per GRANT cycle, clear on entering GRANT, and be wide enough for TIMEOUT-1 without wrap.
REQ-025 GAP SHALL last exactly one cycle with gnt=0 and oPlot=0, then go to IDLE.
  - Minimum turnaround between grants is two idle-grant cycles (GAP, IDLE).
REQ-026 A preempted normal requester that keeps req high SHALL be re-eligible in round-robin after port 0 releases; the arbiter keeps no job state for it.
REQ-027 last SHALL update only on grants to ports 1-3, so urgent grants do not disturb normal fairness.
REQ-028 The output register SHALL NOT combinationally depend on any input.
REQ-029 A requester that drops req while not granted SHALL have no effect.

Reset
REQ-030 While resetn=0 at an edge, the block SHALL set:
  - state=IDLE, gnt=0, oPlot=0, oX=0, oY=0, oColour=0, oTimeout=0;
  - hold counter=0, last=3 (port 1 wins first among normal ports).
REQ-031 Reset asserted mid-grant SHALL abort the grant in the same edge, with no further oPlot.
REQ-032 Arbitration SHALL begin on the first edge after resetn returns high.

Verification
REQ-033 Single job: after reset, req=0010, pix_valid[1]=1 with (x,y,c)=(5,7,3) for 3 cycles, then req=0.
  - Required: gnt=0010 one cycle after req.
  - Required: oPlot=1 with oX=5, oY=7, oColour=3 one cycle after each pixel.
  - Required: GAP, then IDLE.
REQ-034 Round robin: req=1110 held, each port releasing after 2 cycles of grant.
  - Required: grant order 1,2,3,1; gnt never two-hot; two-cycle gap between grants.
REQ-035 Preemption: port 2 granted, req[0] rises.
  - Required: next edge gnt=0 (GAP), then IDLE, then gnt=0001.
  - Required: after port 0 releases, port 3 or 2 is granted per last=2 (port 3 first if requesting).
REQ-036 Timeout: TIMEOUT=8, port 3 holds req forever.
  - Required: gnt=1000 for exactly 8 cycles, then GAP with oTimeout=1 for one cycle, then re-grant of port 3 if it is the only requester.
REQ-037 Reset mid-grant: resetn=0 during port 1 grant with pix_valid=1.
  - Required: next edge gnt=0, oPlot=0, oX/oY/oColour=0, busy=0; the first grant after reset goes to port 1.
REQ-038 Ignored pixels: port 2 asserts pix_valid=1 while port 1 is granted with pix_valid=0.
  - Required: oPlot=0 and oX/oY hold their previous values.

Source files
------------

// File: rtl/vga_write_arbiter.sv
// Four-port pixel-write arbiter for the VGA frame buffer: port 0 is urgent,
// ports 1-3 share round-robin, one registered pixel write per cycle.
module vga_write_arbiter #(
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int TIMEOUT = 131072
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [3:0]       req,
  input  logic [3:0]       pix_valid,
  input  logic [4*X_W-1:0] x_in,
  input  logic [4*Y_W-1:0] y_in,
  input  logic [11:0]      col_in,
  output logic [3:0]       gnt,
  output logic [X_W-1:0]   oX,
  output logic [Y_W-1:0]   oY,
  output logic [2:0]       oColour,
  output logic             oPlot,
  output logic             busy,
  output logic             oTimeout
);

  localparam int HOLD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [X_W-1:0]    ox_q, ox_d;
  logic [Y_W-1:0]    oy_q, oy_d;
  logic [2:0]        ocol_q, ocol_d;
  logic              oplot_q, oplot_d;
  logic              otimeout_q, otimeout_d;

  logic [1:0]        win;
  logic              win_found;
  logic [1:0]        cand;
  logic              g_req;
  logic              g_pv;
  logic [X_W-1:0]    g_x;
  logic [Y_W-1:0]    g_y;
  logic [2:0]        g_c;

  // Urgent port wins outright; otherwise scan ports last+1.. cyclically over 1..3.
  always_comb begin
    win       = 2'd0;
    win_found = 1'b0;
    cand      = 2'd1;
    if (!req[0]) begin
      for (int unsigned k = 1; k <= 3; k++) begin
        cand = 2'((32'(last_q) + k + 2) % 3 + 1);
        if (!win_found && req[cand]) begin
          win       = cand;
          win_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    g_req = 1'b0;
    g_pv  = 1'b0;
    g_x   = '0;
    g_y   = '0;
    g_c   = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      if (gnt_q[p]) begin
        g_req = req[p];
        g_pv  = pix_valid[p];
        g_x   = x_in[p*X_W +: X_W];
        g_y   = y_in[p*Y_W +: Y_W];
        g_c   = col_in[p*3 +: 3];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    hold_d     = hold_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    ocol_d     = ocol_q;
    oplot_d    = 1'b0;
    otimeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          hold_d  = '0;
          if (win != 2'd0) last_d = win;
        end
      end
      GRANT: begin
        oplot_d = g_pv;
        if (g_pv) begin
          ox_d   = g_x;
          oy_d   = g_y;
          ocol_d = g_c;
        end
        hold_d = hold_q + 1'b1;
        // Release and preemption take precedence, so oTimeout marks only a true expiry.
        if (!g_req || (req[0] && !gnt_q[0])) begin
          state_d = GAP;
          gnt_d   = '0;
        end else if (hold_q == HOLD_W'(TIMEOUT - 1)) begin
          state_d    = GAP;
          gnt_d      = '0;
          otimeout_d = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_q     <= 2'd3;
      hold_q     <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      ocol_q     <= '0;
      oplot_q    <= 1'b0;
      otimeout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      ocol_q     <= ocol_d;
      oplot_q    <= oplot_d;
      otimeout_q <= otimeout_d;
    end
  end

  assign gnt      = gnt_q;
  assign oX       = ox_q;
  assign oY       = oy_q;
  assign oColour  = ocol_q;
  assign oPlot    = oplot_q;
  assign oTimeout = otimeout_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed cycle-by-cycle bench for vga_write_arbiter: vector table plus a
// hand-written grant-timeout sequence, all with hand-computed expectations.
module tb_vga_write_arbiter;

  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int TO  = 8;

  logic             clk = 1'b0;
  logic             resetn;
  logic [3:0]       req;
  logic [3:0]       pix_valid;
  logic [4*X_W-1:0] x_in;
  logic [4*Y_W-1:0] y_in;
  logic [11:0]      col_in;
  logic [3:0]       gnt;
  logic [X_W-1:0]   oX;
  logic [Y_W-1:0]   oY;
  logic [2:0]       oColour;
  logic             oPlot;
  logic             busy;
  logic             oTimeout;

  always #5 clk = ~clk;

  vga_write_arbiter #(.X_W(X_W), .Y_W(Y_W), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .req(req), .pix_valid(pix_valid),
    .x_in(x_in), .y_in(y_in), .col_in(col_in), .gnt(gnt),
    .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot),
    .busy(busy), .oTimeout(oTimeout)
  );

  typedef struct {
    logic       rstn;
    logic [3:0] req;
    logic [3:0] pv;
    int         src;
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] c;
    logic [3:0] e_gnt;
    logic       e_plot;
    logic [9:0] e_x;
    logic [8:0] e_y;
    logic [2:0] e_c;
    logic       e_busy;
    logic       e_to;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input logic rstn, input logic [3:0] rq, input logic [3:0] pv,
                              input int src, input int x, input int y, input int c,
                              input logic [3:0] g, input logic pl, input int ex, input int ey,
                              input int ec, input logic b, input logic t);
    vec_t v;
    v.rstn = rstn; v.req = rq; v.pv = pv; v.src = src;
    v.x = 10'(x); v.y = 9'(y); v.c = 3'(c);
    v.e_gnt = g; v.e_plot = pl; v.e_x = 10'(ex); v.e_y = 9'(ey); v.e_c = 3'(ec);
    v.e_busy = b; v.e_to = t;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Port src presents (x,y,c); every other port presents distinct junk.
  task automatic drive(input logic rstn, input logic [3:0] rq, input logic [3:0] pv,
                       input int src, input logic [9:0] x, input logic [8:0] y, input logic [2:0] c);
    resetn    = rstn;
    req       = rq;
    pix_valid = pv;
    for (int p = 0; p < 4; p++) begin
      x_in[p*X_W +: X_W] = (p == src) ? x : 10'(1000 + p);
      y_in[p*Y_W +: Y_W] = (p == src) ? y : 9'(500 + p);
      col_in[p*3 +: 3]   = (p == src) ? c : 3'(p);
    end
  endtask

  task automatic step_check(input string tag, input logic [3:0] e_gnt, input logic e_plot,
                            input int e_x, input int e_y, input int e_c,
                            input logic e_busy, input logic e_to);
    @(posedge clk);
    #1;
    chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'd1);
    chk({tag, ".oPlot"}, 32'(oPlot), 32'(e_plot));
    chk({tag, ".oX"}, 32'(oX), 32'(e_x));
    chk({tag, ".oY"}, 32'(oY), 32'(e_y));
    chk({tag, ".oColour"}, 32'(oColour), 32'(e_c));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".oTimeout"}, 32'(oTimeout), 32'(e_to));
  endtask

  initial begin
    drive(1'b0, 4'b0000, 4'b0000, 1, 10'd0, 9'd0, 3'd0);

    // reset, with a request pending that must be ignored
    add(0,4'b0000,4'b0000,1, 0,0,0,   4'b0000,0, 0,0,0, 0,0);
    add(0,4'b0010,4'b0000,1, 0,0,0,   4'b0000,0, 0,0,0, 0,0);
    // round robin 1,2,3,1 with 2-cycle grants and GAP+IDLE turnaround
    add(1,4'b1110,4'b0000,1, 0,0,0,   4'b0010,0, 0,0,0, 1,0);
    add(1,4'b1110,4'b0000,1, 0,0,0,   4'b0010,0, 0,0,0, 1,0);
    add(1,4'b1100,4'b0000,1, 0,0,0,   4'b0000,0, 0,0,0, 1,0);
    add(1,4'b1110,4'b0000,1, 0,0,0,   4'b0000,0, 0,0,0, 0,0);
    add(1,4'b1110,4'b0000,1, 0,0,0,   4'b0100,0, 0,0,0, 1,0);
    add(1,4'b1110,4'b0000,1, 0,0,0,   4'b0100,0, 0,0,0, 1,0);
    add(1,4'b1010,4'b0000,1, 0,0,0,   4'b0000,0, 0,0,0, 1,0);
    add(1,4'b1110,4'b0000,1, 0,0,0,   4'b0000,0, 0,0,0, 0,0);
    add(1,4'b1110,4'b0000,1, 0,0,0,   4'b1000,0, 0,0,0, 1,0);
    add(1,4'b1110,4'b0000,1, 0,0,0,   4'b1000,0, 0,0,0, 1,0);
    add(1,4'b0110,4'b0000,1, 0,0,0,   4'b0000,0, 0,0,0, 1,0);
    add(1,4'b1110,4'b0000,1, 0,0,0,   4'b0000,0, 0,0,0, 0,0);
    add(1,4'b1110,4'b0000,1, 0,0,0,   4'b0010,0, 0,0,0, 1,0);
    add(1,4'b1110,4'b0000,1, 0,0,0,   4'b0010,0, 0,0,0, 1,0);
    add(1,4'b0000,4'b0000,1, 0,0,0,   4'b0000,0, 0,0,0, 1,0);
    add(1,4'b0000,4'b0000,1, 0,0,0,   4'b0000,0, 0,0,0, 0,0);
    // single job on port 1; exit-cycle pixel still written
    add(1,4'b0010,4'b0010,1, 5,7,3,   4'b0010,0, 0,0,0, 1,0);
    add(1,4'b0010,4'b0010,1, 5,7,3,   4'b0010,1, 5,7,3, 1,0);
    add(1,4'b0010,4'b0010,1, 6,8,4,   4'b0010,1, 6,8,4, 1,0);
    add(1,4'b0000,4'b0010,1, 7,9,5,   4'b0000,1, 7,9,5, 1,0);
    add(1,4'b0000,4'b0000,1, 0,0,0,   4'b0000,0, 7,9,5, 0,0);
    add(1,4'b0000,4'b0000,1, 0,0,0,   4'b0000,0, 7,9,5, 0,0);
    // non-granted port 2 pixels are ignored
    add(1,4'b0010,4'b0100,1, 0,0,0,   4'b0010,0, 7,9,5, 1,0);
    add(1,4'b0010,4'b0100,1, 0,0,0,   4'b0010,0, 7,9,5, 1,0);
    add(1,4'b0010,4'b0010,1, 11,12,6, 4'b0010,1, 11,12,6, 1,0);
    add(1,4'b0000,4'b0100,1, 0,0,0,   4'b0000,0, 11,12,6, 1,0);
    add(1,4'b0000,4'b0000,1, 0,0,0,   4'b0000,0, 11,12,6, 0,0);
    // port 2 preempted by port 0, then port 3 wins on last=2
    add(1,4'b0100,4'b0000,2, 0,0,0,   4'b0100,0, 11,12,6, 1,0);
    add(1,4'b1100,4'b0100,2, 20,21,1, 4'b0100,1, 20,21,1, 1,0);
    add(1,4'b1101,4'b0100,2, 22,23,2, 4'b0000,1, 22,23,2, 1,0);
    add(1,4'b1101,4'b0000,2, 0,0,0,   4'b0000,0, 22,23,2, 0,0);
    add(1,4'b1101,4'b0000,0, 0,0,0,   4'b0001,0, 22,23,2, 1,0);
    add(1,4'b1101,4'b0001,0, 30,31,7, 4'b0001,1, 30,31,7, 1,0);
    add(1,4'b1100,4'b0000,0, 0,0,0,   4'b0000,0, 30,31,7, 1,0);
    add(1,4'b1100,4'b0000,0, 0,0,0,   4'b0000,0, 30,31,7, 0,0);
    add(1,4'b1100,4'b0000,0, 0,0,0,   4'b1000,0, 30,31,7, 1,0);
    add(1,4'b0000,4'b0000,0, 0,0,0,   4'b0000,0, 30,31,7, 1,0);
    add(1,4'b0000,4'b0000,0, 0,0,0,   4'b0000,0, 30,31,7, 0,0);
    // reset mid-grant aborts everything; first grant afterwards is port 1
    add(1,4'b0010,4'b0000,1, 0,0,0,   4'b0010,0, 30,31,7, 1,0);
    add(1,4'b0010,4'b0010,1, 50,51,6, 4'b0010,1, 50,51,6, 1,0);
    add(0,4'b0010,4'b0010,1, 52,53,7, 4'b0000,0, 0,0,0, 0,0);
    add(1,4'b1110,4'b0000,1, 0,0,0,   4'b0010,0, 0,0,0, 1,0);
    add(1,4'b0000,4'b0000,1, 0,0,0,   4'b0000,0, 0,0,0, 1,0);
    add(1,4'b0000,4'b0000,1, 0,0,0,   4'b0000,0, 0,0,0, 0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].rstn, vecs[i].req, vecs[i].pv, vecs[i].src, vecs[i].x, vecs[i].y, vecs[i].c);
      step_check($sformatf("v%0d", i), vecs[i].e_gnt, vecs[i].e_plot, int'(vecs[i].e_x),
                 int'(vecs[i].e_y), int'(vecs[i].e_c), vecs[i].e_busy, vecs[i].e_to);
    end

    // timeout: port 3 alone holds req; gnt high exactly TO cycles, then GAP with oTimeout
    drive(1'b1, 4'b1000, 4'b0000, 3, 10'd0, 9'd0, 3'd0);
    step_check("to.grant", 4'b1000, 1'b0, 0, 0, 0, 1'b1, 1'b0);
    drive(1'b1, 4'b1000, 4'b1000, 3, 10'd40, 9'd41, 3'd4);
    step_check("to.pix", 4'b1000, 1'b1, 40, 41, 4, 1'b1, 1'b0);
    for (int k = 2; k < TO; k++) begin
      drive(1'b1, 4'b1000, 4'b0000, 3, 10'd0, 9'd0, 3'd0);
      step_check($sformatf("to.hold%0d", k), 4'b1000, 1'b0, 40, 41, 4, 1'b1, 1'b0);
    end
    step_check("to.gap", 4'b0000, 1'b0, 40, 41, 4, 1'b1, 1'b1);
    step_check("to.idle", 4'b0000, 1'b0, 40, 41, 4, 1'b0, 1'b0);
    step_check("to.regrant", 4'b1000, 1'b0, 40, 41, 4, 1'b1, 1'b0);
    drive(1'b1, 4'b0000, 4'b0000, 3, 10'd0, 9'd0, 3'd0);
    step_check("to.release", 4'b0000, 1'b0, 40, 41, 4, 1'b1, 1'b0);
    step_check("to.end", 4'b0000, 1'b0, 40, 41, 4, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
